sub_arbiter: RTL
================

Name: sub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one SUB datapath instance among NUM_REQ requesters.
- Accepts one operand pair at a time over a valid/ready handshake and registers the operands.
- Drives the shared subtractor and captures its difference plus an unsigned borrow flag.
- Returns the result tagged with the requester index; sits between client blocks and the single SUB instance in the datapath.

Parameters:
- DATAWIDTH, 32, operand/result width; matches SUB.DATAWIDTH.
- NUM_REQ, 4, number of requesters; legal range 2..8.
- IDW, 2, requester-index width; must equal clog2(NUM_REQ).
- CNTW, 16, width of the completed-operation counter.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  reset, synchronous, active-low (asserted when 0, sampled on rising Clk).
- req_valid  input  NUM_REQ  per-requester request strobe.
- req_a  input  NUM_REQ*DATAWIDTH  minuends; requester i uses bits [i*DATAWIDTH +: DATAWIDTH].
- req_b  input  NUM_REQ*DATAWIDTH  subtrahends; same packing as req_a.
- req_ready  output  NUM_REQ  one-hot accept; at most one bit set.
- sub_a  output  DATAWIDTH  to shared SUB input a.
- sub_b  output  DATAWIDTH  to shared SUB input b.
- sub_diff  input  DATAWIDTH  from shared SUB output diff (combinational).
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  IDW  index of the requester that owns the result.
- resp_diff  output  DATAWIDTH  a - b, modulo 2^DATAWIDTH.
- resp_borrow  output  1  1 when a < b (unsigned).
- busy  output  1  high whenever state is not IDLE.
- op_count  output  CNTW  completed responses; saturates at all-ones.

Behaviour:
- Reset (Rst=0 at a rising edge) sets:
  - state=IDLE, rr_ptr=0, op_a=op_b=0, resp_id=0, resp_diff=0, resp_borrow=0, op_count=0.
  - resp_valid=0, busy=0, req_ready=0.
- Reset overrides all other activity and abandons any in-flight transaction; no response is issued for it.
- sub_a/sub_b are driven from op_a/op_b registers at all times.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - req_ready[winner]=1, decoded combinationally from req_valid and rr_ptr; all other bits 0.
  - If any req_valid is high: latch op_a, op_b and gnt_id=winner, then go to EXEC.
  - If no req_valid is high: stay in IDLE, req_ready=0.
- EXEC (one cycle):
  - Register resp_diff<=sub_diff, resp_borrow<=(op_a<op_b), resp_id<=gnt_id.
  - Go to RESP; req_ready=0.
- RESP:
  - resp_valid=1; resp_id, resp_diff and resp_borrow are held stable.
  - When resp_ready=1: rr_ptr<=(gnt_id+1) mod NUM_REQ, op_count increments (saturating), go to IDLE.
  - When resp_ready=0: hold indefinitely; req_ready stays 0.
- Latency: accept at edge T; resp_valid high in cycle T+2. Minimum spacing between accepts is 3 cycles.
- Requesters:
  - Must hold req_valid, req_a and req_b until they see req_ready.
  - May deassert req_valid before acceptance without penalty.
  - Requests arriving during EXEC or RESP wait.
- Fairness: a requester that holds its request is served within NUM_REQ grants.
- Arithmetic:
  - Unsigned; wrap-around is not an error.
  - resp_borrow is the sole overflow indication.
  - a==b gives diff=0, borrow=0.

Test Plan:
- Reset: hold Rst=0 two cycles with all req_valid=1 -> req_ready=0, resp_valid=0, busy=0, op_count=0, resp_diff=0; first grant after release goes to requester 0.
- Single request: req 2 with a=10, b=3, resp_ready=1 -> req_ready=4'b0100 at T; resp_valid at T+2 with resp_diff=7, resp_borrow=0, resp_id=2; op_count=1.
- Wrap-around: req 0 with a=3, b=5 -> resp_diff=32'hFFFFFFFE, resp_borrow=1. Then a=b=32'h8000_0000 -> diff=0, borrow=0.
- Round-robin: all 4 requesters valid continuously with distinct operands -> grants in order 0,1,2,3,0, each spaced 3 cycles apart; every response carries the matching id and diff.
- Backpressure: resp_ready=0 for 5 cycles during RESP while req 1 is valid -> resp outputs stable, req_ready stays 0, rr_ptr unchanged; resp_ready=1 -> req 1 granted the next cycle.
- Mid-operation reset: assert Rst=0 while in EXEC, then again while in RESP -> next cycle state=IDLE, resp_valid=0, op_count=0, no stale response afterwards.

Source files
------------

// File: rtl/sub_arbiter.sv
// Round-robin front end that time-shares one subtractor among NUM_REQ clients.
// Each accepted operand pair runs IDLE -> EXEC -> RESP and returns a tagged difference.
module sub_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int NUM_REQ   = 4,
    parameter int IDW       = 2,
    parameter int CNTW      = 16
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATAWIDTH-1:0]           sub_a,
    output logic [DATAWIDTH-1:0]           sub_b,
    input  logic [DATAWIDTH-1:0]           sub_diff,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [IDW-1:0]                 resp_id,
    output logic [DATAWIDTH-1:0]           resp_diff,
    output logic                           resp_borrow,
    output logic                           busy,
    output logic [CNTW-1:0]                op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_r;
    logic [IDW-1:0]         rr_ptr_r;
    logic [IDW-1:0]         gnt_id_r;
    logic [DATAWIDTH-1:0]   op_a_r;
    logic [DATAWIDTH-1:0]   op_b_r;
    logic [IDW-1:0]         resp_id_r;
    logic [DATAWIDTH-1:0]   resp_diff_r;
    logic                   resp_borrow_r;
    logic                   resp_valid_r;
    logic                   busy_r;
    logic [CNTW-1:0]        op_count_r;

    logic                   win_found_s;
    logic [IDW-1:0]         win_id_s;
    logic [DATAWIDTH-1:0]   win_a_s;
    logic [DATAWIDTH-1:0]   win_b_s;
    logic [NUM_REQ-1:0]     ready_s;

    // Pointer after a grant: the requester just served moves to lowest priority.
    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
        logic [IDW-1:0] nxt;
        if (int'(id) >= NUM_REQ - 1) begin
            nxt = {IDW{1'b0}};
        end else begin
            nxt = id + {{(IDW-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] cnt);
        logic [CNTW-1:0] res;
        if (&cnt) begin
            res = cnt;
        end else begin
            res = cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = {IDW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr_r) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!win_found_s && req_valid[idx]) begin
                win_found_s = 1'b1;
                win_id_s    = IDW'(idx);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        win_a_s = req_a[int'(win_id_s)*DATAWIDTH +: DATAWIDTH];
        win_b_s = req_b[int'(win_id_s)*DATAWIDTH +: DATAWIDTH];
    end

    // One-hot accept; suppressed while reset is asserted so nothing is handshaken away.
    always_comb begin
        ready_s = {NUM_REQ{1'b0}};
        if (Rst && (state_r == IDLE) && win_found_s) begin
            ready_s[win_id_s] = 1'b1;
        end else begin
            ready_s = {NUM_REQ{1'b0}};
        end
    end

    // Sequencer: grant, one-cycle subtract, then hold the response until consumed.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_r       <= IDLE;
            rr_ptr_r      <= {IDW{1'b0}};
            gnt_id_r      <= {IDW{1'b0}};
            op_a_r        <= {DATAWIDTH{1'b0}};
            op_b_r        <= {DATAWIDTH{1'b0}};
            resp_id_r     <= {IDW{1'b0}};
            resp_diff_r   <= {DATAWIDTH{1'b0}};
            resp_borrow_r <= 1'b0;
            resp_valid_r  <= 1'b0;
            busy_r        <= 1'b0;
            op_count_r    <= {CNTW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        op_a_r   <= win_a_s;
                        op_b_r   <= win_b_s;
                        gnt_id_r <= win_id_s;
                        busy_r   <= 1'b1;
                        state_r  <= EXEC;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                EXEC: begin
                    resp_diff_r   <= sub_diff;
                    resp_borrow_r <= (op_a_r < op_b_r);
                    resp_id_r     <= gnt_id_r;
                    resp_valid_r  <= 1'b1;
                    state_r       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        rr_ptr_r     <= next_ptr(gnt_id_r);
                        op_count_r   <= sat_inc(op_count_r);
                        resp_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        state_r      <= RESP;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = ready_s;
    assign sub_a       = op_a_r;
    assign sub_b       = op_b_r;
    assign resp_valid  = resp_valid_r;
    assign resp_id     = resp_id_r;
    assign resp_diff   = resp_diff_r;
    assign resp_borrow = resp_borrow_r;
    assign busy        = busy_r;
    assign op_count    = op_count_r;

endmodule
